// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store/load type package and MEM-stage-to-store-buffer bus interface
package store_buffer_pkg;
  typedef enum logic [1:0] {
    NO_STORE    = 2'd0,
    STORE_BYTE  = 2'd1,
    STORE_WORD  = 2'd2,
    STORE_DWORD = 2'd3
  } mem_store_type_t;

  typedef enum logic [1:0] {
    NO_LOAD    = 2'd0,
    LOAD_BYTE  = 2'd1,
    LOAD_WORD  = 2'd2,
    LOAD_DWORD = 2'd3
  } mem_load_type_t;
endpackage

interface store_buffer_if;
  import store_buffer_pkg::*;

  mem_store_type_t st_type;
  logic [63:0]     st_addr;
  logic [63:0]     st_data;
  mem_load_type_t  ld_type;
  logic [63:0]     ld_addr;
  logic            port_busy;
  mem_store_type_t mem_store_type;
  logic [63:0]     mem_addr;
  logic [63:0]     mem_data;
  logic            stall;
  logic            empty;

  modport slave (
    input  st_type, st_addr, st_data, ld_type, ld_addr, port_busy,
    output mem_store_type, mem_addr, mem_data, stall, empty
  );

  modport master (
    output st_type, st_addr, st_data, ld_type, ld_addr, port_busy,
    input  mem_store_type, mem_addr, mem_data, stall, empty
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer draining to data memory, stalls overlapping loads
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int INDEX_LEN = 17
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  mem_store_type_t r_type [DEPTH];
  logic [63:0]     r_addr [DEPTH];
  logic [63:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;

  logic w_drain;
  logic w_st_stall;
  logic w_push;
  logic w_ld_hazard;
  logic w_unused_ld;

  function automatic logic [3:0] st_span(input mem_store_type_t t);
    case (t)
      STORE_BYTE:  return 4'd1;
      STORE_WORD:  return 4'd4;
      STORE_DWORD: return 4'd8;
      default:     return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] ld_span(input mem_load_type_t t);
    case (t)
      LOAD_BYTE:  return 4'd1;
      LOAD_WORD:  return 4'd4;
      LOAD_DWORD: return 4'd8;
      default:    return 4'd0;
    endcase
  endfunction

  assign w_drain    = (r_count != '0) && !bus.port_busy;
  assign w_st_stall = (bus.st_type != NO_STORE) && (r_count == FULL_CNT) && !w_drain;
  assign w_push     = (bus.st_type != NO_STORE) && !w_st_stall;

  // Spans use one extra bit so a span ending at 2^INDEX_LEN does not wrap to zero
  always_comb begin
    logic [INDEX_LEN:0] w_ld_lo;
    logic [INDEX_LEN:0] w_ld_hi;
    logic [INDEX_LEN:0] w_st_lo;
    logic [INDEX_LEN:0] w_st_hi;
    w_ld_hazard = 1'b0;
    w_ld_lo = {1'b0, bus.ld_addr[INDEX_LEN-1:0]};
    w_ld_hi = w_ld_lo + (INDEX_LEN+1)'(ld_span(bus.ld_type));
    w_st_lo = '0;
    w_st_hi = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_st_lo = {1'b0, r_addr[i][INDEX_LEN-1:0]};
      w_st_hi = w_st_lo + (INDEX_LEN+1)'(st_span(r_type[i]));
      if (r_valid[i] && (bus.ld_type != NO_LOAD) && (w_st_lo < w_ld_hi) && (w_ld_lo < w_st_hi))
        w_ld_hazard = 1'b1;
    end
  end

  assign w_unused_ld = &{1'b0, bus.ld_addr[63:INDEX_LEN]};

  assign bus.mem_store_type = w_drain ? r_type[r_head] : NO_STORE;
  assign bus.mem_addr       = w_drain ? r_addr[r_head] : 64'd0;
  assign bus.mem_data       = w_drain ? r_data[r_head] : 64'd0;
  assign bus.stall          = w_st_stall | w_ld_hazard;
  assign bus.empty          = (r_count == '0);

  // When full and draining, tail equals head: the push must win the valid bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_type[i] <= NO_STORE;
        r_addr[i] <= 64'd0;
        r_data[i] <= 64'd0;
      end
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_type[r_tail]  <= bus.st_type;
        r_addr[r_tail]  <= bus.st_addr;
        r_data[r_tail]  <= bus.st_data;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    mem_store_type_t t;
    logic [63:0]     a;
    logic [63:0]     d;
  } sb_entry_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  sb_entry_t q[$];

  store_buffer_if bus();

  store_buffer #(.DEPTH(DEPTH), .INDEX_LEN(17)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input mem_store_type_t st, input logic [63:0] sa, input logic [63:0] sd,
                      input mem_load_type_t lt, input logic [63:0] la, input logic busy,
                      input logic exp_haz, output logic acc);
    logic exp_drain;
    logic exp_sst;
    sb_entry_t e;
    bus.st_type   = st;
    bus.st_addr   = sa;
    bus.st_data   = sd;
    bus.ld_type   = lt;
    bus.ld_addr   = la;
    bus.port_busy = busy;
    @(negedge clk);
    exp_drain = (q.size() > 0) && !busy;
    exp_sst   = (st != NO_STORE) && (q.size() == DEPTH) && !exp_drain;
    chk("empty", bus.empty, q.size() == 0);
    chk("stall", bus.stall, exp_sst | exp_haz);
    chk("drain", bus.mem_store_type != NO_STORE, exp_drain);
    if (exp_drain) begin
      e = q.pop_front();
      chk("drain_type", bus.mem_store_type, e.t);
      chk("drain_addr", bus.mem_addr, e.a);
      chk("drain_data", bus.mem_data, e.d);
    end else begin
      chk("idle_addr", bus.mem_addr, 64'd0);
      chk("idle_data", bus.mem_data, 64'd0);
    end
    acc = (st != NO_STORE) && !exp_sst;
    if (acc) begin
      e.t = st;
      e.a = sa;
      e.d = sd;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic busy);
    logic acc;
    step(NO_STORE, 64'd0, 64'd0, NO_LOAD, 64'd0, busy, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    int   tries;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.st_type   = NO_STORE;
    bus.st_addr   = 64'd0;
    bus.st_data   = 64'd0;
    bus.ld_type   = NO_LOAD;
    bus.ld_addr   = 64'd0;
    bus.port_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_type", bus.mem_store_type, NO_STORE);
    chk("rst_addr", bus.mem_addr, 64'd0);
    chk("rst_data", bus.mem_data, 64'd0);
    chk("rst_stall", bus.stall, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single store
    step(STORE_WORD, 64'h100, 64'hDEADBEEF, NO_LOAD, 64'd0, 1'b0, 1'b0, acc);
    idle(1'b0);
    idle(1'b0);

    // fill, overflow stall, then drain with simultaneous push
    for (int i = 0; i < 5; i++) begin
      step(STORE_BYTE, 64'(i), 64'(8'hA0 + i), NO_LOAD, 64'd0, 1'b1, 1'b0, acc);
      chk("fill_acc", acc, i < 4);
    end
    step(STORE_BYTE, 64'd4, 64'hA4, NO_LOAD, 64'd0, 1'b0, 1'b0, acc);
    chk("full_drain_acc", acc, 1'b1);
    tries = 0;
    while (q.size() > 0 && tries < 10) begin
      idle(1'b0);
      tries++;
    end
    chk("fill_drained", q.size(), 0);

    // load hazard
    step(STORE_DWORD, 64'h200, 64'h1122334455667788, NO_LOAD, 64'd0, 1'b1, 1'b0, acc);
    step(NO_STORE, 64'd0, 64'd0, LOAD_BYTE,  64'h207,   1'b1, 1'b1, acc);
    step(NO_STORE, 64'd0, 64'd0, LOAD_BYTE,  64'h208,   1'b1, 1'b0, acc);
    step(NO_STORE, 64'd0, 64'd0, LOAD_DWORD, 64'h1F8,   1'b1, 1'b0, acc);
    step(NO_STORE, 64'd0, 64'd0, LOAD_WORD,  64'h1FD,   1'b1, 1'b1, acc);
    step(NO_STORE, 64'd0, 64'd0, LOAD_BYTE,  64'h20200, 1'b1, 1'b1, acc);
    step(NO_STORE, 64'd0, 64'd0, LOAD_BYTE,  64'h207,   1'b0, 1'b1, acc);
    step(NO_STORE, 64'd0, 64'd0, LOAD_BYTE,  64'h207,   1'b0, 1'b0, acc);

    // pointer wrap with alternating port_busy
    tries = 0;
    for (int i = 0; i < 10; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      acc = 1'b0;
      while (!acc && tries < 40) begin
        step(STORE_DWORD, 64'h1000 + 64'(8 * i), d, NO_LOAD, 64'd0, 1'(tries % 2), 1'b0, acc);
        tries++;
      end
      chk("wrap_acc", acc, 1'b1);
    end
    tries = 0;
    while (q.size() > 0 && tries < 10) begin
      idle(1'b0);
      tries++;
    end
    chk("wrap_drained", q.size(), 0);

    // reset mid-operation
    for (int i = 0; i < 3; i++)
      step(STORE_WORD, 64'h300 + 64'(4 * i), 64'(i + 7), NO_LOAD, 64'd0, 1'b1, 1'b0, acc);
    bus.st_type   = NO_STORE;
    bus.port_busy = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_empty", bus.empty, 1'b1);
    chk("mid_rst_type", bus.mem_store_type, NO_STORE);
    chk("mid_rst_stall", bus.stall, 1'b0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(STORE_BYTE, 64'h55, 64'h5A, NO_LOAD, 64'd0, 1'b0, 1'b0, acc);
    chk("post_rst_acc", acc, 1'b1);
    repeat (3) idle(1'b0);
    chk("post_rst_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries (power of two, >=2).
REQ-002 SHALL have parameter INDEX_LEN, default 17, address bits used for overlap compare (matches data memory byte-index width).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port st_type  input  mem_store_type_t  store request from MEM stage; NO_STORE = none.
REQ-006 SHALL have port st_addr  input  64  store byte address.
REQ-007 SHALL have port st_data  input  64  store data, low bytes significant.
REQ-008 SHALL have port ld_type  input  mem_load_type_t  load in MEM stage; NO_LOAD = none.
REQ-009 SHALL have port ld_addr  input  64  load byte address.
REQ-010 SHALL have port port_busy  input  1  data memory port unavailable for draining this cycle.
REQ-011 SHALL have port mem_store_type  output  mem_store_type_t  store type driven to data memory.
REQ-012 SHALL have port mem_addr  output  64  store address to data memory.
REQ-013 SHALL have port mem_data  output  64  store data to data memory.
REQ-014 SHALL have port stall  output  1  pipeline must hold MEM stage this cycle.
REQ-015 SHALL have port empty  output  1  no valid entries.

Function
REQ-016 SHALL hold entries as a circular FIFO: head/tail pointers wrap modulo DEPTH, count 0..DEPTH.
REQ-017 SHALL define drain = (count>0) & !port_busy; combinational.
REQ-018 SHALL drive mem_store_type = head type, mem_addr/mem_data = head fields when drain, else NO_STORE with addr/data = 0.
REQ-019 SHALL pop the head at posedge when drain (memory commits on the following negedge within the same cycle).
REQ-020 SHALL define st_stall = (st_type!=NO_STORE) & (count==DEPTH) & !drain.
REQ-021 SHALL push {st_type, st_addr, st_data} at tail at posedge when st_type!=NO_STORE and !st_stall; full with simultaneous drain accepts the push (count unchanged).
REQ-022 SHALL give entry byte span: BYTE=1, WORD=4, DWORD=8; load span likewise from ld_type.
REQ-023 SHALL flag ld_hazard when ld_type!=NO_LOAD and any valid entry span overlaps load span, compared on [INDEX_LEN-1:0] of addresses without wrap-around beyond 2^INDEX_LEN.
REQ-024 SHALL NOT forward data; a hazarding load waits until overlapping entries drain.
REQ-025 SHALL drive stall = st_stall | ld_hazard.
REQ-026 SHALL preserve program order: drains strictly FIFO; a store pushed in cycle N is never drained before cycle N+1.
REQ-027 SHALL drive empty = (count==0).
REQ-028 SHALL ignore st_addr/st_data when st_type==NO_STORE and ld_addr when ld_type==NO_LOAD.

Reset
REQ-029 SHALL on reset assertion immediately clear count, head, tail, all entry valid state, discarding pending stores.
REQ-030 SHALL drive after reset: mem_store_type=NO_STORE, mem_addr=0, mem_data=0, stall=0, empty=1.
REQ-031 SHALL accept a push on the first posedge after reset deassertion.

Verification
REQ-032 SHALL cover single store: STORE_WORD addr 0x100 data 0xDEADBEEF, port_busy=0 -> next cycle mem_store_type=STORE_WORD, mem_addr=0x100, mem_data=0xDEADBEEF; cycle after, empty=1.
REQ-033 SHALL cover fill: port_busy=1, push 5 STORE_BYTE -> first 4 accepted, 5th raises stall=1; drop port_busy -> 5th accepted same cycle as first drain, drain order addr 0,1,2,3,4.
REQ-034 SHALL cover load hazard: pending STORE_DWORD at 0x200, port_busy=1, LOAD_BYTE at 0x207 -> stall=1; LOAD_BYTE at 0x208 -> stall=0; release port_busy -> stall clears after drain.
REQ-035 SHALL cover pointer wrap: 10 stores with alternating port_busy -> all 10 reach memory in order with correct data.
REQ-036 SHALL cover reset mid-operation: 3 pending entries, assert reset between clock edges -> empty=1, mem_store_type=NO_STORE immediately; no pending store ever drained.
